acorn128_phase_ctrl: RTL and testbench
======================================

Name: acorn128_phase_ctrl

Overview:
Bit-serial phase sequencer for the ACORN-128 core. It sits directly upstream of the state-update stage. It produces the per-step message bit (mbit), control bits ca/cb and a step strobe for each of the cipher phases: key/IV initialisation, associated-data absorption, plaintext processing and finalisation. It paces AD and message bits with a valid/ready handshake, flags which steps carry ciphertext or tag bits, and pulses done at the end.

Parameters:
LEN_W, 16, width of ad_len/msg_len bit-count inputs (max 2^LEN_W-1 bits each)
INIT_RPT, 1536, number of key-repeat initialisation steps
FINAL_STEPS, 768, number of finalisation steps
TAG_BITS, 128, number of final steps flagged as tag output

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  begin an operation; sampled only in IDLE
key  in  128  key; key[0] is injected first
iv  in  128  nonce; iv[0] is injected first
ad_len  in  LEN_W  associated-data length in bits; latched on start
msg_len  in  LEN_W  message length in bits; latched on start
din  in  1  serial AD/plaintext bit
din_valid  in  1  din is valid
din_ready  out  1  controller consumes din this cycle when din_valid=1
step_en  out  1  state-update stage advances one step this cycle
mbit  out  1  message bit for this step
ca  out  1  ca control bit for this step
cb  out  1  cb control bit for this step
ct_valid  out  1  this step's keystream bit XOR din is a ciphertext bit (MSG phase)
tag_valid  out  1  this step's keystream bit is a tag bit
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last finalisation step

Behaviour:
- Reset: all state goes to IDLE. Step counter = 0. Latched key/iv/lengths = 0. All outputs = 0.
- Outputs are combinational from the registered state, the counter n, and din/din_valid. The step counter n advances when step_en=1. A phase transition occurs on the step where n reaches the phase length minus 1; n then clears to 0.
- Counter width: 11 bits, which covers the maximum of 1536. A separate LEN_W counter is used in the AD and MSG phases.
- IDLE: start=1 latches key, iv, ad_len and msg_len, then moves to INIT_KEY next cycle. start is ignored outside IDLE.
- INIT_KEY, 128 steps: step_en=1, mbit=key[n], ca=1, cb=1.
- INIT_IV, 128 steps: step_en=1, mbit=iv[n], ca=1, cb=1.
- INIT_RPT, INIT_RPT steps: step_en=1, mbit=key[n mod 128], with n=0 inverted (key[0]^1). ca=1, cb=1.
- AD, ad_len steps: din_ready=1, step_en=din_valid, mbit=din, ca=1, cb=1. With ad_len=0, go straight to AD_PAD with no cycle spent in AD.
- AD_PAD, 256 steps: step_en=1, mbit=(n==0), ca=(n<128), cb=1.
- MSG, msg_len steps: din_ready=1, step_en=din_valid, ct_valid=din_valid, mbit=din, ca=1, cb=0. With msg_len=0, skip to MSG_PAD.
- MSG_PAD, 256 steps: step_en=1, mbit=(n==0), ca=(n<128), cb=0.
- FINAL, FINAL_STEPS steps: step_en=1, mbit=0, ca=1, cb=1. tag_valid=1 for n >= FINAL_STEPS-TAG_BITS.
- DONE, 1 cycle: done=1, busy=1, step_en=0, then IDLE.
- din_ready=0 in every state other than AD and MSG. din_valid there is ignored and not consumed.
- din_valid low in AD/MSG: step_en=0, counters hold, and ca/cb/mbit keep their phase values. The stage is stalled, not advanced.
- Total steps with zero-length AD and message: 1792+256+256+768 = 3072. Wall cycles = 1 (IDLE→) + 3072 + 1 (DONE).
- Reset mid-operation: immediate return to IDLE with all outputs 0. There is no resume.
- start held high through DONE: a new operation begins only after returning to IDLE, at the earliest 1 cycle after done.

Test Plan:
- Reset with rst=0 during an operation → busy=0, step_en=0, done=0 within the same cycle, asynchronously. After rst=1 the block stays in IDLE.
- start, key=128'h1, iv=0, ad_len=0, msg_len=0 → step 0: mbit=1, ca=1, cb=1. Step 256 (INIT_RPT n=0): mbit=0, since key[0]^1. Step 384: mbit=1. done exactly 3073 cycles after start. Total step_en count 3072.
- ad_len=3, din_valid toggled 1,0,1,0,1 with din=1,x,0,x,1 → exactly 3 AD steps with mbit 1,0,1. Stall cycles have step_en=0. The next step is AD_PAD n=0 with mbit=1, ca=1, cb=1.
- msg_len=8 with continuous din_valid → 8 steps with ct_valid=1, ca=1, cb=0. MSG_PAD step 128 has ca=0, cb=0, mbit=0.
- FINAL phase → tag_valid high for exactly 128 consecutive steps, namely the final 128 of the 768 with ca=1, cb=1, mbit=0. done pulses 1 cycle after the last of them.
- din_valid=1 asserted during INIT_KEY and FINAL → din_ready=0 and no extra steps. Step count is unchanged versus the idle-din case.

Source files
------------

// File: rtl/acorn128_phase_ctrl.sv
// ---------------------------------------------------------------------------
// acorn128_phase_ctrl
//
// Bit-serial phase sequencer feeding the ACORN-128 state-update stage. Walks
// through key/IV initialisation, associated-data absorption, message
// processing and finalisation, producing one (mbit, ca, cb) triple per step
// together with a step strobe. AD and message bits are paced by a
// valid/ready handshake on din.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   start               begin an operation (only looked at in IDLE)
//   key, iv             128-bit key / nonce, bit 0 injected first
//   ad_len, msg_len     AD / message lengths in bits, latched on start
//   din, din_valid      serial AD / plaintext bit and its valid
//   din_ready           din is consumed this cycle when din_valid=1
//   step_en             state-update stage advances one step this cycle
//   mbit, ca, cb        per-step message bit and control bits
//   ct_valid            this step yields a ciphertext bit
//   tag_valid           this step yields a tag bit
//   busy                high in every state except IDLE
//   done                one-cycle pulse after the last finalisation step
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module acorn128_phase_ctrl #(
   parameter int LEN_W       = 16,
   parameter int INIT_RPT    = 1536,
   parameter int FINAL_STEPS = 768,
   parameter int TAG_BITS    = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [127:0]     key,
   input  logic [127:0]     iv,
   input  logic [LEN_W-1:0] ad_len,
   input  logic [LEN_W-1:0] msg_len,
   input  logic             din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             step_en,
   output logic             mbit,
   output logic             ca,
   output logic             cb,
   output logic             ct_valid,
   output logic             tag_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT_KEY, S_INIT_IV, S_INIT_RPT, S_AD,
      S_AD_PAD, S_MSG, S_MSG_PAD, S_FINAL, S_DONE
   } state_t;

   localparam logic [10:0]      N_ONE       = 11'd1;
   localparam logic [10:0]      N_BLK_LAST  = 11'd127;
   localparam logic [10:0]      N_PAD_LAST  = 11'd255;
   localparam logic [10:0]      N_HALF      = 11'd128;
   localparam logic [10:0]      N_RPT_LAST  = 11'(INIT_RPT - 1);
   localparam logic [10:0]      N_FIN_LAST  = 11'(FINAL_STEPS - 1);
   localparam logic [10:0]      N_TAG_FIRST = 11'(FINAL_STEPS - TAG_BITS);
   localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);

   state_t             state_q, state_d;
   logic [10:0]        n_q, n_d;         // step index inside fixed-length phases
   logic [LEN_W-1:0]   len_q, len_d;     // step index inside AD / MSG
   logic [127:0]       key_q, key_d;
   logic [127:0]       iv_q, iv_d;
   logic [LEN_W-1:0]   ad_len_q, ad_len_d;
   logic [LEN_W-1:0]   msg_len_q, msg_len_d;

   // Per-step outputs, decoded from the registered state and counters.
   always_comb begin
      din_ready = 1'b0;
      step_en   = 1'b0;
      mbit      = 1'b0;
      ca        = 1'b0;
      cb        = 1'b0;
      ct_valid  = 1'b0;
      tag_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state_q)
         S_IDLE: busy = 1'b0;
         S_INIT_KEY: begin
            step_en = 1'b1;
            mbit    = key_q[n_q[6:0]];
            ca      = 1'b1;
            cb      = 1'b1;
         end
         S_INIT_IV: begin
            step_en = 1'b1;
            mbit    = iv_q[n_q[6:0]];
            ca      = 1'b1;
            cb      = 1'b1;
         end
         S_INIT_RPT: begin
            // Key is cycled repeatedly; the very first repeat bit is flipped.
            step_en = 1'b1;
            mbit    = key_q[n_q[6:0]] ^ (n_q == '0);
            ca      = 1'b1;
            cb      = 1'b1;
         end
         S_AD: begin
            din_ready = 1'b1;
            step_en   = din_valid;
            mbit      = din;
            ca        = 1'b1;
            cb        = 1'b1;
         end
         S_AD_PAD: begin
            step_en = 1'b1;
            mbit    = (n_q == '0);
            ca      = (n_q < N_HALF);
            cb      = 1'b1;
         end
         S_MSG: begin
            din_ready = 1'b1;
            step_en   = din_valid;
            ct_valid  = din_valid;
            mbit      = din;
            ca        = 1'b1;
         end
         S_MSG_PAD: begin
            step_en = 1'b1;
            mbit    = (n_q == '0);
            ca      = (n_q < N_HALF);
         end
         S_FINAL: begin
            step_en   = 1'b1;
            ca        = 1'b1;
            cb        = 1'b1;
            tag_valid = (n_q >= N_TAG_FIRST);
         end
         S_DONE: done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // Next-state / counter logic. Each phase ends on the step where its
   // counter reaches length-1; the counter then clears for the next phase.
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      len_d     = len_q;
      key_d     = key_q;
      iv_d      = iv_q;
      ad_len_d  = ad_len_q;
      msg_len_d = msg_len_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               key_d     = key;
               iv_d      = iv;
               ad_len_d  = ad_len;
               msg_len_d = msg_len;
               n_d       = '0;
               len_d     = '0;
               state_d   = S_INIT_KEY;
            end
         end
         S_INIT_KEY: begin
            if (n_q == N_BLK_LAST) begin
               n_d     = '0;
               state_d = S_INIT_IV;
            end else begin
               n_d = n_q + N_ONE;
            end
         end
         S_INIT_IV: begin
            if (n_q == N_BLK_LAST) begin
               n_d     = '0;
               state_d = S_INIT_RPT;
            end else begin
               n_d = n_q + N_ONE;
            end
         end
         S_INIT_RPT: begin
            if (n_q == N_RPT_LAST) begin
               n_d     = '0;
               // Empty AD never spends a cycle in S_AD.
               state_d = (ad_len_q == '0) ? S_AD_PAD : S_AD;
            end else begin
               n_d = n_q + N_ONE;
            end
         end
         S_AD: begin
            if (din_valid) begin
               if (len_q == ad_len_q - LEN_ONE) begin
                  len_d   = '0;
                  state_d = S_AD_PAD;
               end else begin
                  len_d = len_q + LEN_ONE;
               end
            end
         end
         S_AD_PAD: begin
            if (n_q == N_PAD_LAST) begin
               n_d     = '0;
               state_d = (msg_len_q == '0) ? S_MSG_PAD : S_MSG;
            end else begin
               n_d = n_q + N_ONE;
            end
         end
         S_MSG: begin
            if (din_valid) begin
               if (len_q == msg_len_q - LEN_ONE) begin
                  len_d   = '0;
                  state_d = S_MSG_PAD;
               end else begin
                  len_d = len_q + LEN_ONE;
               end
            end
         end
         S_MSG_PAD: begin
            if (n_q == N_PAD_LAST) begin
               n_d     = '0;
               state_d = S_FINAL;
            end else begin
               n_d = n_q + N_ONE;
            end
         end
         S_FINAL: begin
            if (n_q == N_FIN_LAST) begin
               n_d     = '0;
               state_d = S_DONE;
            end else begin
               n_d = n_q + N_ONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         len_q     <= '0;
         key_q     <= '0;
         iv_q      <= '0;
         ad_len_q  <= '0;
         msg_len_q <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         len_q     <= len_d;
         key_q     <= key_d;
         iv_q      <= iv_d;
         ad_len_q  <= ad_len_d;
         msg_len_q <= msg_len_d;
      end
   end

endmodule

// File: tb/tb_acorn128_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_acorn128_phase_ctrl
//
// Bench for the ACORN-128 phase sequencer. For every operation a flat list of
// expected steps is built phase by phase; a compare process walks that list
// on every busy cycle. Hand-computed literal expectations pin key points.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_acorn128_phase_ctrl;

   localparam int INIT_RPT    = 1536;
   localparam int FINAL_STEPS = 768;
   localparam int TAG_BITS    = 128;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key;
   logic [127:0] iv;
   logic [15:0]  ad_len;
   logic [15:0]  msg_len;
   logic         din;
   logic         din_valid;
   logic         din_ready, step_en, mbit, ca, cb, ct_valid, tag_valid, busy, done;

   acorn128_phase_ctrl #(
      .LEN_W(16), .INIT_RPT(INIT_RPT), .FINAL_STEPS(FINAL_STEPS), .TAG_BITS(TAG_BITS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv),
      .ad_len(ad_len), .msg_len(msg_len), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .step_en(step_en), .mbit(mbit), .ca(ca), .cb(cb),
      .ct_valid(ct_valid), .tag_valid(tag_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic dat;   // step belongs to AD or MSG (handshaked)
      logic mbit;
      logic ca;
      logic cb;
      logic ct;
      logic tag;
   } step_t;

   typedef struct packed {
      logic v;
      logic b;
   } item_t;

   step_t exp_q[$];
   item_t stim_q[$];

   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   int   start_cyc = 0;
   int   done_cyc  = 0;
   int   step_cnt  = 0;
   bit   op_active = 0;
   bit   done_seen = 0;
   logic idle_v    = 1'b0;
   logic rdy;
   logic log_mbit [4096];
   logic log_ca   [4096];
   logic log_cb   [4096];
   logic log_ct   [4096];
   logic log_tag  [4096];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic step_t mk(input logic d, input logic m, input logic a,
                                input logic b, input logic c, input logic t);
      step_t s;
      s.dat = d; s.mbit = m; s.ca = a; s.cb = b; s.ct = c; s.tag = t;
      return s;
   endfunction

   // Expected step sequence of one operation, phase by phase. AD/MSG bits are
   // the valid entries of the stimulus list, in order.
   task automatic build_model(input logic [127:0] k, input logic [127:0] v,
                              input int adl, input int ml);
      logic vb[$];
      exp_q.delete();
      foreach (stim_q[i]) if (stim_q[i].v) vb.push_back(stim_q[i].b);
      for (int i = 0; i < 128; i++) exp_q.push_back(mk(0, k[i], 1, 1, 0, 0));
      for (int i = 0; i < 128; i++) exp_q.push_back(mk(0, v[i], 1, 1, 0, 0));
      for (int i = 0; i < INIT_RPT; i++)
         exp_q.push_back(mk(0, k[i % 128] ^ (i == 0), 1, 1, 0, 0));
      for (int i = 0; i < adl; i++) exp_q.push_back(mk(1, vb[i], 1, 1, 0, 0));
      for (int i = 0; i < 256; i++) exp_q.push_back(mk(0, i == 0, i < 128, 1, 0, 0));
      for (int i = 0; i < ml; i++) exp_q.push_back(mk(1, vb[adl + i], 1, 0, 1, 0));
      for (int i = 0; i < 256; i++) exp_q.push_back(mk(0, i == 0, i < 128, 0, 0, 0));
      for (int i = 0; i < FINAL_STEPS; i++)
         exp_q.push_back(mk(0, 0, 1, 1, 0, i >= FINAL_STEPS - TAG_BITS));
   endtask

   // Compare process: every busy cycle of an active operation.
   step_t h;
   logic  e_step, e_mbit;
   always @(negedge clk) begin
      if (op_active && cyc > start_cyc) begin
         if (done) begin
            chk("done_status", {28'd0, busy, done, step_en, din_ready}, 32'hC);
            chk("done_queue_empty", exp_q.size(), 0);
            done_cyc  = cyc;
            done_seen = 1;
            op_active = 0;
         end else if (exp_q.size() == 0) begin
            chk("missing_done", {31'd0, done}, 1);
            op_active = 0;
         end else begin
            h      = exp_q[0];
            e_step = h.dat ? din_valid : 1'b1;
            e_mbit = e_step ? h.mbit : din;
            chk("step_outputs",
                {23'd0, busy, done, step_en, din_ready, mbit, ca, cb, ct_valid, tag_valid},
                {23'd0, 1'b1, 1'b0, e_step, h.dat, e_mbit, h.ca, h.cb, h.ct & e_step, h.tag});
            if (e_step) exp_q.delete(0);
            if (step_en) begin
               if (step_cnt < 4096) begin
                  log_mbit[step_cnt] = mbit;
                  log_ca[step_cnt]   = ca;
                  log_cb[step_cnt]   = cb;
                  log_ct[step_cnt]   = ct_valid;
                  log_tag[step_cnt]  = tag_valid;
               end
               step_cnt++;
            end
         end
      end
   end

   task automatic present_din();
      if (stim_q.size() > 0) begin
         din_valid = stim_q[0].v;
         din       = stim_q[0].b;
      end else begin
         din_valid = idle_v;
         din       = 1'($urandom);
      end
   endtask

   task automatic run_op(input logic [127:0] k, input logic [127:0] v,
                         input int adl, input int ml, input bit hold);
      build_model(k, v, adl, ml);
      step_cnt  = 0;
      done_seen = 0;
      for (int i = 0; i < 4096; i++) begin
         log_mbit[i] = 0; log_ca[i] = 0; log_cb[i] = 0; log_ct[i] = 0; log_tag[i] = 0;
      end
      @(posedge clk); #1;
      key = k; iv = v; ad_len = adl[15:0]; msg_len = ml[15:0]; start = 1'b1;
      present_din();
      @(negedge clk); #1;
      start_cyc = cyc;
      op_active = 1;
      for (int c = 0; c < 5000 && !done_seen; c++) begin
         rdy = din_ready;
         @(posedge clk); #1;
         if (!hold) start = 1'b0;
         if (rdy && stim_q.size() > 0) stim_q.delete(0);
         present_din();
         @(negedge clk); #1;
      end
      if (!done_seen) begin
         chk("op_timeout", {31'd0, done_seen}, 1);
         op_active = 0;
      end
   endtask

   int cnt;
   logic busy_seen;
   logic [4:0] ad_v, ad_b;
   logic [7:0] msg_b;

   initial begin
      rst = 1'b0; start = 1'b0; key = '0; iv = '0; ad_len = '0; msg_len = '0;
      din = 1'b0; din_valid = 1'b0;
      #2;
      chk("reset_outputs",
          {23'd0, busy, done, step_en, din_ready, mbit, ca, cb, ct_valid, tag_valid}, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Zero-length AD and message, din idle.
      idle_v = 1'b0;
      run_op(128'h1, 128'h0, 0, 0, 0);
      $display("op A: key=1 ad=0 msg=0 steps=%0d done_latency=%0d", step_cnt, done_cyc - start_cyc);
      chk("A_step0", {29'd0, log_mbit[0], log_ca[0], log_cb[0]}, 3'b111);
      chk("A_step1_mbit", {31'd0, log_mbit[1]}, 0);
      chk("A_step256_mbit", {31'd0, log_mbit[256]}, 0);
      chk("A_step384_mbit", {31'd0, log_mbit[384]}, 1);
      chk("A_done_latency", done_cyc - start_cyc, 3073);
      chk("A_step_count", step_cnt, 3072);
      cnt = 0;
      for (int i = 0; i < 3072; i++) cnt += int'(log_tag[i]);
      chk("A_tag_count", cnt, 128);
      chk("A_tag_edges", {29'd0, log_tag[2943], log_tag[2944], log_tag[3071]}, 3'b011);
      chk("A_final_ctl", {29'd0, log_mbit[3000], log_ca[3000], log_cb[3000]}, 3'b011);

      // ad_len=3 with stalls, msg_len=8 continuous.
      ad_v  = 5'b10101;   // item i valid = ad_v[i]: 1,0,1,0,1
      ad_b  = 5'b11001;   // item bits 1,0,0,1,1 -> valid bits 1,0,1
      msg_b = 8'b01001101; // 1,0,1,1,0,0,1,0
      stim_q.delete();
      for (int i = 0; i < 5; i++) stim_q.push_back(item_t'({ad_v[i], ad_b[i]}));
      for (int i = 0; i < 8; i++) stim_q.push_back(item_t'({1'b1, msg_b[i]}));
      idle_v = 1'b0;
      run_op(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
             128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0, 3, 8, 0);
      $display("op C: ad=3 msg=8 steps=%0d", step_cnt);
      chk("C_ad_mbits", {29'd0, log_mbit[1792], log_mbit[1793], log_mbit[1794]}, 3'b101);
      chk("C_adpad0", {29'd0, log_mbit[1795], log_ca[1795], log_cb[1795]}, 3'b111);
      chk("C_msg_ctl", {29'd0, log_ct[2051], log_ca[2051], log_cb[2051]}, 3'b110);
      chk("C_msg_mbits", {29'd0, log_mbit[2051], log_mbit[2052], log_mbit[2054]}, 3'b101);
      cnt = 0;
      for (int i = 0; i < 4096; i++) cnt += int'(log_ct[i]);
      chk("C_ct_count", cnt, 8);
      chk("C_msgpad127", {29'd0, log_mbit[2186], log_ca[2186], log_cb[2186]}, 3'b010);
      chk("C_msgpad128", {29'd0, log_mbit[2187], log_ca[2187], log_cb[2187]}, 3'b000);
      chk("C_step_count", step_cnt, 3083);

      // din_valid high everywhere, start held high through DONE.
      idle_v = 1'b1;
      stim_q.delete();
      run_op(128'hDEAD_BEEF_0000_FFFF_1357_9BDF_2468_ACE0,
             128'h8000_0000_0000_0000_0000_0000_0000_0001, 0, 0, 1);
      $display("op B: din_valid=1 start held steps=%0d", step_cnt);
      chk("B_step_count", step_cnt, 3072);
      @(negedge clk);
      chk("B_idle_after_done", {31'd0, busy}, 0);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("B_restart", {30'd0, busy, step_en}, 2'b11);
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("B_async_reset", {28'd0, busy, step_en, done, din_ready}, 0);
      @(posedge clk); #1 rst = 1'b1;
      busy_seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         busy_seen = busy_seen | busy;
      end
      chk("B_stay_idle", {31'd0, busy_seen}, 0);
      $display("op B: reset mid-operation, stayed idle");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
